// File: rtl/tictactoe_pkg.sv
// -----------------------------------------------------------------------------
// tictactoe_pkg
// Shared definitions for the tic-tac-toe datapath:
//   - cell codes (EMPTY / PLAYER / COMPUTER)
//   - result codes reported on `who` (NONE / P_WIN / C_WIN / DRAW)
//   - game controller FSM state enum
//   - the 8 winning lines as zero-based cell index triples
//     (cell index 0 is pos1, index 8 is pos9)
// -----------------------------------------------------------------------------
package tictactoe_pkg;

  // Cell contents
  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER   = 2'b01;
  localparam logic [1:0] COMPUTER = 2'b10;

  // Game result codes
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] P_WIN = 2'b01;
  localparam logic [1:0] C_WIN = 2'b10;
  localparam logic [1:0] DRAW  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    P_TURN,
    P_CHECK,
    C_TURN,
    C_CHECK,
    DONE
  } state_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/nospace_detector.sv
// -----------------------------------------------------------------------------
// nospace_detector
// Combinational board-full detector.
// Ports:
//   pos1..pos9  in  2 each  cell contents
//   no_space    out 1       high when every cell is non-empty
// -----------------------------------------------------------------------------
module nospace_detector (
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       no_space
);

  assign no_space = (|pos1) && (|pos2) && (|pos3) &&
                    (|pos4) && (|pos5) && (|pos6) &&
                    (|pos7) && (|pos8) && (|pos9);

endmodule

// File: rtl/tictactoe_line_check.sv
// -----------------------------------------------------------------------------
// tictactoe_line_check
// Combinational win detector: flags when any of the 8 lines is entirely
// owned by `mark`.
// Ports:
//   cells     in  9x2  board, cells[0] = pos1 ... cells[8] = pos9
//   mark      in  2    cell code to test (PLAYER or COMPUTER)
//   line_hit  out 1    high if some line is fully `mark`
// -----------------------------------------------------------------------------
module tictactoe_line_check
  import tictactoe_pkg::*;
(
  input  logic [NUM_CELLS-1:0][1:0] cells,
  input  logic [1:0]                mark,
  output logic                      line_hit
);

  logic [NUM_LINES-1:0] hits;

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    assign hits[gi] = (cells[WIN_LINES[gi][0]] == mark) &&
                      (cells[WIN_LINES[gi][1]] == mark) &&
                      (cells[WIN_LINES[gi][2]] == mark);
  end

  assign line_hit = |hits;

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// -----------------------------------------------------------------------------
// tictactoe_game_ctrl
// Turn sequencer and board owner. Holds the nine cell registers, grants
// alternate write access to the player and computer, rejects illegal moves
// and evaluates win/draw one cycle after every accepted move.
// Parameters:
//   FIRST_MOVE   0 = player moves first after start, 1 = computer
// Ports:
//   clock         in  1   system clock
//   reset_n       in  1   asynchronous active-low reset
//   start         in  1   clear board and begin a game (outranks strobes)
//   play          in  1   player move strobe
//   player_pos    in  4   player target cell 1..9
//   pc            in  1   computer move strobe
//   pc_pos        in  4   computer target cell 1..9
//   pos1..pos9    out 2   cell contents (00 empty, 01 player, 10 computer)
//   turn          out 2   side to move (00 none, 01 player, 10 computer)
//   illegal_move  out 1   registered pulse after a rejected strobe
//   who           out 2   result (00 none, 01 player, 10 computer, 11 draw)
//   game_over     out 1   high while the game is finished
// -----------------------------------------------------------------------------
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter bit FIRST_MOVE = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       play,
  input  logic [3:0] player_pos,
  input  logic       pc,
  input  logic [3:0] pc_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       illegal_move,
  output logic [1:0] who,
  output logic       game_over
);

  localparam state_t FIRST_STATE = FIRST_MOVE ? C_TURN : P_TURN;

  state_t                    state_reg;
  logic [NUM_CELLS-1:0][1:0] board_reg;
  logic [1:0]                who_reg;
  logic                      illegal_reg;

  // Only the side whose turn it is has its strobe looked at; the other
  // side's strobe never reaches the legality logic.
  logic       player_side;
  logic       move_strobe;
  logic [3:0] move_pos;
  logic [1:0] move_mark;
  logic       move_in_range;
  logic       move_occupied;
  logic       move_legal;

  assign player_side   = (state_reg == P_TURN);
  assign move_strobe   = player_side ? play       : pc;
  assign move_pos      = player_side ? player_pos : pc_pos;
  assign move_mark     = player_side ? PLAYER     : COMPUTER;
  assign move_in_range = (move_pos >= 4'd1) && (move_pos <= 4'd9);

  always_comb begin
    move_occupied = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_pos == 4'(i + 1)) begin
        move_occupied = (board_reg[i] != EMPTY);
      end
    end
  end

  assign move_legal = move_in_range && !move_occupied;

  // Win/draw evaluation on the registered board. Only the side that just
  // moved can have completed a line, so a single detector suffices.
  logic [1:0] check_mark;
  logic       line_hit;
  logic       no_space;

  assign check_mark = (state_reg == C_CHECK) ? COMPUTER : PLAYER;

  tictactoe_line_check u_line_check (
    .cells    (board_reg),
    .mark     (check_mark),
    .line_hit (line_hit)
  );

  nospace_detector u_nospace (
    .pos1     (board_reg[0]),
    .pos2     (board_reg[1]),
    .pos3     (board_reg[2]),
    .pos4     (board_reg[3]),
    .pos5     (board_reg[4]),
    .pos6     (board_reg[5]),
    .pos7     (board_reg[6]),
    .pos8     (board_reg[7]),
    .pos9     (board_reg[8]),
    .no_space (no_space)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      board_reg   <= '0;
      who_reg     <= NONE;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      if (start) begin
        board_reg <= '0;
        who_reg   <= NONE;
        state_reg <= FIRST_STATE;
      end else begin
        case (state_reg)
          P_TURN, C_TURN: begin
            if (move_strobe) begin
              if (move_legal) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                  if (move_pos == 4'(i + 1)) begin
                    board_reg[i] <= move_mark;
                  end
                end
                state_reg <= player_side ? P_CHECK : C_CHECK;
              end else begin
                illegal_reg <= 1'b1;
              end
            end
          end
          P_CHECK, C_CHECK: begin
            if (line_hit) begin
              who_reg   <= (state_reg == P_CHECK) ? P_WIN : C_WIN;
              state_reg <= DONE;
            end else if (no_space) begin
              who_reg   <= DRAW;
              state_reg <= DONE;
            end else begin
              state_reg <= (state_reg == P_CHECK) ? C_TURN : P_TURN;
            end
          end
          IDLE, DONE: begin
            // Wait for start; strobes have no effect.
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    turn = 2'b00;
    if (state_reg == P_TURN) turn = 2'b01;
    if (state_reg == C_TURN) turn = 2'b10;
  end

  assign game_over    = (state_reg == DONE);
  assign who          = who_reg;
  assign illegal_move = illegal_reg;

  assign pos1 = board_reg[0];
  assign pos2 = board_reg[1];
  assign pos3 = board_reg[2];
  assign pos4 = board_reg[3];
  assign pos5 = board_reg[4];
  assign pos6 = board_reg[5];
  assign pos7 = board_reg[6];
  assign pos8 = board_reg[7];
  assign pos9 = board_reg[8];

endmodule
